threebit_serial_sub: RTL and testbench

Bit-serial subtractor that computes `a - b` one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. It is the inverse counterpart of the team's combinational three-bit ripple adder. It sits beside the adder in the datapath: the adder's operands and results can be fed through it so the bench can check round-trip consistency. A start/busy/done handshake frames each operation.

---
 rtl/threebit_serial_sub.sv | 161 ++++++++++++++++
 tb/tb_threebit_serial_sub.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/threebit_serial_sub.sv
// -----------------------------------------------------------------------------
// threebit_serial_sub
//
// Bit-serial subtractor: computes (a - b) mod 2^WIDTH one bit per clock, LSB
// first, through a single full-subtractor cell and a registered borrow.
// A start/busy/done handshake frames each operation. Companion to the
// combinational three-bit ripple adder, so results can be round-tripped.
//
// Optional feature macro: THREEBIT_SUB_OVF_EN
//   defined   -> adds the 'ovf' output (two's-complement overflow of a - b)
//   undefined -> 'ovf' port and its logic are absent
//
// Parameters
//   WIDTH   operand/result width in bits, legal range 2..8 (default 3)
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset
//   start   in   request, sampled only while idle
//   a       in   minuend, captured when start is accepted
//   b       in   subtrahend, captured when start is accepted
//   diff    out  registered (a - b) mod 2^WIDTH
//   borrow  out  registered final borrow (a < b unsigned)
//   busy    out  high while bits are being processed
//   done    out  one-cycle pulse when diff/borrow/ovf update
//   ovf     out  signed overflow flag (only with THREEBIT_SUB_OVF_EN)
// -----------------------------------------------------------------------------
module threebit_serial_sub #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             busy,
   output logic             done
`ifdef THREEBIT_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   // Counter holds 0..WIDTH; one spare bit so it never wraps.
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sa;        // minuend shift register, current bit at [0]
   logic [WIDTH-1:0] sb;        // subtrahend shift register, current bit at [0]
   logic [WIDTH-1:0] part;      // partial difference
   logic [WIDTH-1:0] part_nxt;
   logic [CW-1:0]    cnt;       // index of the bit processed this cycle
   logic             bin;       // registered borrow into the current bit
   logic             d_bit;
   logic             bout;
   logic             last;

`ifdef THREEBIT_SUB_OVF_EN
   // Sign bits of the captured operands; the shift registers lose them.
   logic             a_msb;
   logic             b_msb;
`endif

   // Full-subtractor cell and the partial result with the current bit placed.
   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      d_bit    = sa[0] ^ sb[0] ^ bin;
      bout     = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bin);
      last     = (cnt == CW'(WIDTH - 1));
      part_nxt = part;
      for (int i = 0; i < WIDTH; i++) begin
         if (cnt == CW'(i)) begin
            part_nxt[i] = d_bit;
         end
      end
   end

   // Control FSM with registered outputs.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   // NOTE: reset is synchronous and clears every register, including the
   // datapath, so an aborted operation leaves no stale partial state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         sa     <= '0;
         sb     <= '0;
         part   <= '0;
         cnt    <= '0;
         bin    <= 1'b0;
         diff   <= '0;
         borrow <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
`ifdef THREEBIT_SUB_OVF_EN
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
         ovf    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  sa    <= a;
                  sb    <= b;
                  part  <= '0;
                  cnt   <= '0;
                  bin   <= 1'b0;
                  busy  <= 1'b1;
                  state <= RUN;
`ifdef THREEBIT_SUB_OVF_EN
                  a_msb <= a[WIDTH-1];
                  b_msb <= b[WIDTH-1];
`endif
               end
            end

            RUN: begin
               sa   <= sa >> 1;
               sb   <= sb >> 1;
               part <= part_nxt;
               bin  <= bout;
               cnt  <= cnt + CW'(1);
               if (last) begin
                  diff   <= part_nxt;
                  borrow <= bout;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  state  <= DONE;
`ifdef THREEBIT_SUB_OVF_EN
                  // d_bit is the result MSB on the last bit.
                  ovf    <= (a_msb != b_msb) && (d_bit != a_msb);
`endif
               end
            end

            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_threebit_serial_sub.sv
// -----------------------------------------------------------------------------
// tb_threebit_serial_sub
//
// Self-checking bench for threebit_serial_sub. Expected results come from a
// plain-arithmetic model of a - b (unsigned modulo, unsigned compare, signed
// range check); handshake timing is checked cycle by cycle.
// Honours THREEBIT_SUB_OVF_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_threebit_serial_sub;

   localparam int W = 3;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] diff;
   logic         borrow;
   logic         busy;
   logic         done;
   logic         ovf_obs;

   int n_checks = 0;
   int n_errors = 0;

   // Last results the outputs must be holding.
   logic [W-1:0] exp_diff;
   logic         exp_borrow;
   logic         exp_ovf;

   threebit_serial_sub #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .diff   (diff),
      .borrow (borrow),
      .busy   (busy),
      .done   (done)
`ifdef THREEBIT_SUB_OVF_EN
      ,
      .ovf    (ovf_obs)
`endif
   );

`ifndef THREEBIT_SUB_OVF_EN
   assign ovf_obs = 1'b0;
`endif

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Advance one edge and settle past it before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: plain integer arithmetic.
   task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                        output logic [W-1:0] md, output logic mbor, output logic movf);
      int ia, ib, sa, sb, r;
      ia   = int'(ma);
      ib   = int'(mb);
      md   = W'((ia - ib + (1 << W)) % (1 << W));
      mbor = (ia < ib);
      sa   = (ia >= (1 << (W - 1))) ? ia - (1 << W) : ia;
      sb   = (ib >= (1 << (W - 1))) ? ib - (1 << W) : ib;
      r    = sa - sb;
      movf = (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
   endtask

   task automatic check_held(input string tag);
      check({tag, "_diff_hold"}, diff, exp_diff);
      check({tag, "_borrow_hold"}, borrow, exp_borrow);
`ifdef THREEBIT_SUB_OVF_EN
      check({tag, "_ovf_hold"}, ovf_obs, exp_ovf);
`endif
   endtask

   // One full operation from IDLE; operands are scrambled and start is
   // toggled after acceptance to prove they are ignored.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv);
      logic [W-1:0] md;
      logic         mbor, movf;
      model(ta, tbv, md, mbor, movf);
      a     = ta;
      b     = tbv;
      start = 1'b1;
      tick();                                   // acceptance edge k
      a     = W'($urandom);
      b     = W'($urandom);
      start = 1'($urandom);
      check("acc_busy", busy, 1);
      check("acc_done", done, 0);
      check_held("acc");
      for (int i = 1; i < W; i++) begin
         tick();
         start = 1'($urandom);
         check("run_busy", busy, 1);
         check("run_done", done, 0);
         check_held("run");
      end
      tick();                                   // edge k+W
      exp_diff   = md;
      exp_borrow = mbor;
      exp_ovf    = movf;
      check("done_pulse", done, 1);
      check("done_busy", busy, 0);
      check("diff", diff, md);
      check("borrow", borrow, mbor);
`ifdef THREEBIT_SUB_OVF_EN
      check("ovf", ovf_obs, movf);
`endif
      tick();                                   // edge k+W+1, start still ignored
      start = 1'b0;
      check("idle_done", done, 0);
      check("idle_busy", busy, 0);
      check_held("idle");
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      exp_diff   = '0;
      exp_borrow = 1'b0;
      exp_ovf    = 1'b0;

      // Reset state.
      tick();
      tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check_held("rst");
      rst = 1'b0;
      tick();
      check("post_rst_busy", busy, 0);

      // Directed cases.
      run_op(3'd6, 3'd1);
      run_op(3'd2, 3'd3);
      run_op(3'd5, 3'd4);
      run_op(3'd0, 3'd7);

      // Abort by reset during the edge that would have produced done.
      a     = 3'd6;
      b     = 3'd1;
      start = 1'b1;
      tick();                                   // accepted
      a     = '0;
      b     = '0;
      start = 1'b1;                             // mid-run start, ignored
      tick();
      start = 1'b0;
      for (int i = 2; i < W; i++) begin
         tick();
         check("abort_run_busy", busy, 1);
      end
      rst = 1'b1;
      tick();                                   // edge k+W with reset
      exp_diff   = '0;
      exp_borrow = 1'b0;
      exp_ovf    = 1'b0;
      check("abort_done", done, 0);
      check("abort_busy", busy, 0);
      check_held("abort");
      rst = 1'b0;
      tick();
      check("abort_idle_done", done, 0);
      check("abort_idle_busy", busy, 0);
      check_held("abort_idle");
      run_op(3'd3, 3'd2);

      run_op(3'd7, 3'd7);
      run_op(3'd3, 3'd7);
      run_op(3'd4, 3'd1);
      run_op(3'd6, 3'd1);

      // Start held high: back-to-back operations every W+2 edges.
      begin
         logic [W-1:0] md;
         logic         mbor, movf;
         model(3'd5, 3'd2, md, mbor, movf);
         a     = 3'd5;
         b     = 3'd2;
         start = 1'b1;
         for (int n = 0; n < 20; n++) begin
            tick();
            if (n % (W + 2) == W) begin
               exp_diff   = md;
               exp_borrow = mbor;
               exp_ovf    = movf;
            end
            check("b2b_done", done, (n % (W + 2) == W) ? 1 : 0);
            check("b2b_busy", busy, (n % (W + 2) < W) ? 1 : 0);
            check("b2b_excl", busy & done, 0);
            check_held("b2b");
         end
         start = 1'b0;
         tick();
         check("b2b_end_busy", busy, 0);
      end

      // Randomized operations.
      for (int k = 0; k < 40; k++) begin
         run_op(W'($urandom), W'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
